// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
//
// Conditions raw, active-low, bouncy push-button inputs. Each key is
// synchronised into clk with a two-flop synchroniser and then debounced by its
// own four-state FSM. Every key produces a clean level plus one-cycle press,
// release and long-hold pulses. All outputs are registered.
//
// There is no valid/ready handshake in this block. Every pulse output is a
// plain one-cycle strobe that the consumer must sample on the clock edge after
// it is registered. The strobe is never held or repeated.
//
// Ports:
//   clk          in   1       system clock, rising edge
//   rst_n        in   1       asynchronous active-low reset
//   key_n        in   N_KEYS  raw keys, 0 = pressed, asynchronous to clk
//   key_level    out  N_KEYS  debounced level, 1 = pressed
//   key_press    out  N_KEYS  one-cycle pulse when a press is accepted
//   key_release  out  N_KEYS  one-cycle pulse when a release is accepted
//   key_hold     out  N_KEYS  one-cycle pulse HOLD_CYCLES after key_press
//   dbg_state    out  2*N_KEYS  FSM state of key k in bits [2k+1:2k]
// -----------------------------------------------------------------------------
module key_conditioner #(
    parameter int N_KEYS          = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 50000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_KEYS-1:0]     key_n,
    output logic [N_KEYS-1:0]     key_level,
    output logic [N_KEYS-1:0]     key_press,
    output logic [N_KEYS-1:0]     key_release,
    output logic [N_KEYS-1:0]     key_hold,
    output logic [2*N_KEYS-1:0]   dbg_state
);

    localparam int MAXC = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] D_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] H_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] H_MAX  = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] ONE    = CW'(1);

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        logic          r_sync1;
        logic          r_sync2;
        state_t        r_state;
        logic [CW-1:0] r_dcnt;
        logic [CW-1:0] r_hcnt;
        logic          r_level;
        logic          r_press;
        logic          r_release;
        logic          r_hold;
        logic          w_s;

        // The FSM only ever looks at the second synchroniser stage.
        assign w_s = r_sync2;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync1   <= 1'b1;
                r_sync2   <= 1'b1;
                r_state   <= ST_RELEASED;
                r_dcnt    <= '0;
                r_hcnt    <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_hold    <= 1'b0;
            end else begin
                r_sync1   <= key_n[k];
                r_sync2   <= r_sync1;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_hold    <= 1'b0;

                // Hold timing runs through RELEASE_WAIT as well, so a release
                // bounce neither restarts nor suppresses the hold pulse. The
                // pulse fires on the edge where hcnt becomes HOLD_CYCLES, and
                // saturation guarantees that happens once per press.
                if (r_state == ST_PRESSED || r_state == ST_RELEASE_WAIT) begin
                    if (r_hcnt != H_MAX) begin
                        r_hcnt <= r_hcnt + ONE;
                    end
                    if (r_hcnt == H_LAST) begin
                        r_hold <= 1'b1;
                    end
                end

                case (r_state)
                    ST_RELEASED: begin
                        if (!w_s) begin
                            r_state <= ST_PRESS_WAIT;
                            r_dcnt  <= ONE;
                        end else begin
                            r_dcnt  <= '0;
                        end
                    end
                    ST_PRESS_WAIT: begin
                        if (w_s) begin
                            r_state <= ST_RELEASED;
                            r_dcnt  <= '0;
                        end else if (r_dcnt == D_LAST) begin
                            r_state <= ST_PRESSED;
                            r_press <= 1'b1;
                            r_level <= 1'b1;
                            r_hcnt  <= '0;
                        end else begin
                            r_dcnt  <= r_dcnt + ONE;
                        end
                    end
                    ST_PRESSED: begin
                        if (w_s) begin
                            r_state <= ST_RELEASE_WAIT;
                            r_dcnt  <= ONE;
                        end
                    end
                    ST_RELEASE_WAIT: begin
                        if (!w_s) begin
                            r_state <= ST_PRESSED;
                            r_dcnt  <= '0;
                        end else if (r_dcnt == D_LAST) begin
                            r_state   <= ST_RELEASED;
                            r_release <= 1'b1;
                            r_level   <= 1'b0;
                        end else begin
                            r_dcnt    <= r_dcnt + ONE;
                        end
                    end
                    default: begin
                        r_state <= ST_RELEASED;
                        r_dcnt  <= '0;
                    end
                endcase
            end
        end

        assign key_level[k]       = r_level;
        assign key_press[k]       = r_press;
        assign key_release[k]     = r_release;
        assign key_hold[k]        = r_hold;
        assign dbg_state[2*k +: 2] = r_state;
    end

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

  localparam int N  = 3;
  localparam int D  = 4;
  localparam int H  = 10;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   key_n;
  logic [N-1:0]   key_level;
  logic [N-1:0]   key_press;
  logic [N-1:0]   key_release;
  logic [N-1:0]   key_hold;
  logic [2*N-1:0] dbg_state;

  int checks;
  int failures;

  key_conditioner #(
    .N_KEYS(N),
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_n(key_n),
    .key_level(key_level),
    .key_press(key_press),
    .key_release(key_release),
    .key_hold(key_hold),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge. Outputs seen afterwards are
  // the values registered at that edge; inputs set afterwards are sampled by
  // the following edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Release every key and let all FSMs settle back into RELEASED.
  task automatic go_idle();
    key_n = '1;
    repeat (14) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key_n = '1;
    repeat (2) step();
    checks++;
    if ({key_level, key_press, key_release, key_hold} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", {key_level, key_press, key_release, key_hold});
    end
    checks++;
    if (dbg_state !== '0) begin
      failures++;
      $display("FAIL reset_state got=%b exp=0", dbg_state);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      checks++;
      if ({key_level, key_press, key_release, key_hold} !== '0) begin
        failures++;
        $display("FAIL idle_outputs e=%0d got=%b exp=0", e, {key_level, key_press, key_release, key_hold});
      end
    end
  endtask

  // Key 0 held from E1: press and level rise registered at E6.
  task automatic test_clean_press();
    key_n[0] = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step();
      checks++;
      if (key_press !== ((e == 6) ? 3'b001 : 3'b000)) begin
        failures++;
        $display("FAIL clean_press e=%0d got=%b exp=%b", e, key_press, (e == 6) ? 3'b001 : 3'b000);
      end
      checks++;
      if (key_level !== ((e >= 6) ? 3'b001 : 3'b000)) begin
        failures++;
        $display("FAIL clean_level e=%0d got=%b exp=%b", e, key_level, (e >= 6) ? 3'b001 : 3'b000);
      end
    end
    // Release: first high sample is E1 of this loop, release registered at E6.
    key_n[0] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      checks++;
      if (key_release !== ((e == 6) ? 3'b001 : 3'b000)) begin
        failures++;
        $display("FAIL clean_release e=%0d got=%b exp=%b", e, key_release, (e == 6) ? 3'b001 : 3'b000);
      end
      checks++;
      if (key_level !== ((e < 6) ? 3'b001 : 3'b000)) begin
        failures++;
        $display("FAIL clean_release_level e=%0d got=%b exp=%b", e, key_level, (e < 6) ? 3'b001 : 3'b000);
      end
    end
    go_idle();
  endtask

  // Key 1 samples 0,0,0,1,0,0,... : aborted wait, then press at E10.
  task automatic test_bounce();
    logic [7:0] pattern;
    int         n_press;
    pattern = 8'b0000_1000;  // bit i = sample for edge E(i+1)
    n_press = 0;
    for (int e = 1; e <= 20; e++) begin
      key_n[1] = (e <= 8) ? pattern[e-1] : 1'b0;
      step();
      if (key_press[1]) n_press++;
      checks++;
      if (key_press[1] !== (e == 10)) begin
        failures++;
        $display("FAIL bounce_press e=%0d got=%b exp=%b", e, key_press[1], (e == 10));
      end
    end
    checks++;
    if (n_press !== 1) begin
      failures++;
      $display("FAIL bounce_press_count got=%0d exp=1", n_press);
    end
    go_idle();
  endtask

  // Key 2 held: press E6, hold E16, no second hold over 50 more cycles.
  task automatic test_hold();
    int n_hold;
    n_hold = 0;
    key_n[2] = 1'b0;
    for (int e = 1; e <= 70; e++) begin
      step();
      if (key_hold[2]) n_hold++;
      checks++;
      if (key_hold !== ((e == 16) ? 3'b100 : 3'b000)) begin
        failures++;
        $display("FAIL hold_pulse e=%0d got=%b exp=%b", e, key_hold, (e == 16) ? 3'b100 : 3'b000);
      end
    end
    checks++;
    if (n_hold !== 1) begin
      failures++;
      $display("FAIL hold_count got=%0d exp=1", n_hold);
    end
    go_idle();
  endtask

  // Key 0 low for samples E1..E8: press E6, release E14, no hold.
  task automatic test_short_tap();
    for (int e = 1; e <= 25; e++) begin
      key_n[0] = (e <= 8) ? 1'b0 : 1'b1;
      step();
      checks++;
      if ({key_press[0], key_release[0], key_hold[0], key_level[0]} !==
          {(e == 6), (e == 14), 1'b0, (e >= 6 && e < 14)}) begin
        failures++;
        $display("FAIL short_tap e=%0d got(p,r,h,l)=%b exp=%b", e,
                 {key_press[0], key_release[0], key_hold[0], key_level[0]},
                 {(e == 6), (e == 14), 1'b0, (e >= 6 && e < 14)});
      end
    end
    go_idle();
  endtask

  // Key 2: high for samples E8,E9 only -> no release, hold still at E16.
  task automatic test_release_bounce();
    for (int e = 1; e <= 25; e++) begin
      key_n[2] = (e == 8 || e == 9) ? 1'b1 : 1'b0;
      step();
      checks++;
      if ({key_press[2], key_release[2], key_hold[2], key_level[2]} !==
          {(e == 6), 1'b0, (e == 16), (e >= 6)}) begin
        failures++;
        $display("FAIL release_bounce e=%0d got(p,r,h,l)=%b exp=%b", e,
                 {key_press[2], key_release[2], key_hold[2], key_level[2]},
                 {(e == 6), 1'b0, (e == 16), (e >= 6)});
      end
    end
    go_idle();
  endtask

  // All keys pressed together: simultaneous pulses in the same cycle.
  task automatic test_simultaneous();
    key_n = 3'b000;
    for (int e = 1; e <= 18; e++) begin
      step();
      checks++;
      if ({key_press, key_hold} !== {((e == 6) ? 3'b111 : 3'b000), ((e == 16) ? 3'b111 : 3'b000)}) begin
        failures++;
        $display("FAIL simultaneous e=%0d got(press,hold)=%b exp=%b", e, {key_press, key_hold},
                 {((e == 6) ? 3'b111 : 3'b000), ((e == 16) ? 3'b111 : 3'b000)});
      end
    end
    go_idle();
  endtask

  // Key 1 pressed and stable, key 0 in PRESS_WAIT, then reset mid-cycle.
  task automatic test_reset_mid_press();
    key_n[1] = 1'b0;
    repeat (8) step();
    checks++;
    if (key_level !== 3'b010) begin
      failures++;
      $display("FAIL pre_reset_level got=%b exp=010", key_level);
    end
    key_n[0] = 1'b0;
    repeat (4) step();
    checks++;
    if (dbg_state[1:0] !== 2'd1) begin
      failures++;
      $display("FAIL pre_reset_state got=%0d exp=1", dbg_state[1:0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({key_level, key_press, key_release, key_hold, dbg_state} !== '0) begin
      failures++;
      $display("FAIL async_reset got=%b exp=0", {key_level, key_press, key_release, key_hold, dbg_state});
    end
    repeat (2) step();
    rst_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      checks++;
      if (key_press !== ((e == 6) ? 3'b011 : 3'b000)) begin
        failures++;
        $display("FAIL post_reset_press e=%0d got=%b exp=%b", e, key_press, (e == 6) ? 3'b011 : 3'b000);
      end
    end
    go_idle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    key_n    = '1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold();
    test_short_tap();
    test_release_bounce();
    test_simultaneous();
    test_reset_mid_press();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Conditions the raw DE1-SoC push-button inputs before they reach the stopwatch control logic. The raw keys are active-low and bouncy. For each key, the block synchronises the input into `clk`, then debounces it with a per-key state machine. It produces a clean pressed level and single-cycle press, release and long-hold pulses. It sits between the board `KEY` pins and the stopwatch start/pause, display-freeze and clear logic, which then needs no debounce counters of its own.

## Interface
- `N_KEYS`, 3: number of independent keys. Bit k of every bus belongs to key k.
- `DEBOUNCE_CYCLES`, 500000: number of consecutive stable samples needed to accept a level change. 500000 is 10 ms at 50 MHz. Legal values are ≥ 2.
- `HOLD_CYCLES`, 50000000: delay from the press pulse to the hold pulse. 50000000 is 1 s. Legal values are ≥ 1.
- `clk`  in  1  50 MHz system clock. All logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_n`  in  N_KEYS  raw keys; 0 = pressed. Asynchronous to `clk`.
- `key_level`  out  N_KEYS  debounced level; 1 = pressed.
- `key_press`  out  N_KEYS  one-cycle pulse when a press is accepted.
- `key_release`  out  N_KEYS  one-cycle pulse when a release is accepted.
- `key_hold`  out  N_KEYS  one-cycle pulse, at most once per accepted press.

## Operation
- Synchroniser, per key:
  - Two flops, both reset to 1 (released).
  - The FSM only sees stage-2 output, referred to below as `s`. `s`=0 means pressed.
- Debounce counter `dcnt` and hold counter `hcnt`, per key:
  - Both are unsigned, `$clog2(max(DEBOUNCE_CYCLES,HOLD_CYCLES)+1)` bits wide.
  - Both reset to 0.
  - `hcnt` saturates at `HOLD_CYCLES`; it never wraps.
- FSM per key, states RELEASED (reset), PRESS_WAIT, PRESSED, RELEASE_WAIT:
  - **RELEASED**: if `s`=0, go to PRESS_WAIT with `dcnt`=1. Otherwise stay, with `dcnt`=0.
  - **PRESS_WAIT**:
    - If `s`=1 (bounce), go to RELEASED with `dcnt`=0. No pulse.
    - Else if `dcnt`==DEBOUNCE_CYCLES−1, go to PRESSED. Assert `key_press` for one cycle, set `key_level`=1 and clear `hcnt` to 0.
    - Else increment `dcnt`.
  - **PRESSED**:
    - `hcnt` increments every cycle.
    - When `hcnt` reaches HOLD_CYCLES, assert `key_hold` for one cycle.
    - If `s`=1, go to RELEASE_WAIT with `dcnt`=1.
  - **RELEASE_WAIT**:
    - `hcnt` keeps counting, and `key_hold` can still fire here.
    - If `s`=0 (bounce), return to PRESSED with `dcnt`=0. No new press pulse; `hcnt` is not cleared.
    - Else if `dcnt`==DEBOUNCE_CYCLES−1, go to RELEASED. Assert `key_release` for one cycle and set `key_level`=0.
    - Else increment `dcnt`.
- `key_hold` fires at most once between `key_press` and the next accepted release. It does not fire if the release is accepted before `hcnt` reaches HOLD_CYCLES.
- Keys are fully independent. Simultaneous presses on several keys produce simultaneous pulses in the same cycle.
- All outputs are registered; there are no combinational paths from input to output.
- Reset:
  - `rst_n`=0 immediately forces every synchroniser flop to 1, every FSM to RELEASED, and every counter and output to 0, including any pulse in progress.
  - If a key is held across reset release, it is treated as a new press: `key_press` fires after the full debounce.

## Timing
- Press latency:
  - Let E1 be the first rising edge that samples the raw `key_n`=0, and assume the key stays low.
  - `key_press` and the `key_level` rise are registered at edge E(DEBOUNCE_CYCLES+2).
  - `key_press` is high for exactly that one cycle.
- Release latency: symmetric to press. `key_release` and the `key_level` fall are registered at edge E(DEBOUNCE_CYCLES+2), counted from the first edge that samples `key_n`=1.
- Hold latency: if `key_press` is registered at edge Ep, `key_hold` is registered at edge Ep+HOLD_CYCLES.
- Glitch rejection: a low pulse on `key_n` of fewer than DEBOUNCE_CYCLES consecutive samples produces no output change.
- Within one key, `key_press` and `key_release` are never high in the same cycle.
- `key_hold` never coincides with `key_press`. It can coincide with the entry into RELEASE_WAIT.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and HOLD_CYCLES=10.
- **Clean press:** hold `key_n[0]`=0 from E1 → `key_press[0]`=1 only in the cycle after E6, and `key_level[0]`=1 from E6 onward.
- **Bounce:** drive `key_n[1]` as 0,0,0,1,0,0,0,0 per cycle → no pulse during the first three-low run. `key_press[1]` is registered 4 samples after the sync output re-goes low, exactly once.
- **Hold:** press key 2 and keep it held → `key_hold[2]` is registered 10 edges after `key_press[2]`, exactly once. Holding 50 more cycles gives no second hold pulse.
- **Short tap:** press for 8 cycles, then release → `key_press`, then `key_release` 6 edges after the first high sample. No `key_hold`. `key_level` returns to 0.
- **Release bounce:** while pressed, drive `key_n`=1 for 2 cycles, then 0 → no `key_release`, no new `key_press`, and `key_hold` still fires on schedule.
- **Reset mid-press:** assert `rst_n`=0 during PRESS_WAIT, with `key_n[0]` held low → all outputs 0 at once. After `rst_n` rises, `key_press[0]` fires 6 edges after the first edge that samples the key.
